// File: rtl/run_ctrl_if.sv
// run_ctrl_if -- control bus between the run controller and its core/bench.
//   master : drives start, halt_inst, pc; observes the run status outputs
//   slave  : the run controller itself
//   start       level request: high loads/holds the core in init, falling edge runs
//   halt_inst   decoded halt instruction present at the current pc
//   pc          current core program counter
//   core_init   hold core state and fetch PC at initial values
//   core_en     gates PC advance, regfile writes and data-memory writes
//   done        run finished (halt or timeout)
//   timeout     run ended by the cycle bound rather than a halt instruction
//   cycle_count instructions executed in the current/last run
//   halt_pc     pc captured when the run ended
interface run_ctrl_if #(
  parameter int PC_WIDTH  = 11,
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic                 halt_inst;
  logic [PC_WIDTH-1:0]  pc;
  logic                 core_init;
  logic                 core_en;
  logic                 done;
  logic                 timeout;
  logic [CNT_WIDTH-1:0] cycle_count;
  logic [PC_WIDTH-1:0]  halt_pc;

  modport master (
    output start, halt_inst, pc,
    input  core_init, core_en, done, timeout, cycle_count, halt_pc
  );

  modport slave (
    input  start, halt_inst, pc,
    output core_init, core_en, done, timeout, cycle_count, halt_pc
  );
endinterface

// File: rtl/run_ctrl.sv
// run_ctrl -- sequences a core through IDLE -> INIT -> RUN -> HALT.
//   clk    single clock, all state on the rising edge
//   reset  asynchronous active-low reset
//   bus    run_ctrl_if.slave (start/halt_inst/pc in, run status out)
// A run starts on the falling edge of start, ends on a halt instruction
// (which is never executed) or after TIMEOUT executed cycles. Raising start
// at any point after IDLE re-enters INIT and clears the run results.
// Only core_en depends combinationally on inputs; every other output is a
// flop or a pure state decode.
module run_ctrl #(
  parameter int PC_WIDTH  = 11,
  parameter int CNT_WIDTH = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic        clk,
  input  logic        reset,
  run_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, INIT, RUN, HALT} state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [PC_WIDTH-1:0]  halt_pc_q;
  logic                 tmo_q;

  logic                 en;       // this RUN cycle executes an instruction
  logic                 fin;      // run ends on this edge
  logic                 tmo_hit;  // ...and it ends by the cycle bound
  logic                 clr;      // entering/holding INIT: wipe run results

  // Next state and per-cycle control. Priority inside RUN: abort (start)
  // beats halt, halt beats timeout, so a halt landing on the last allowed
  // cycle is reported as a halt and is not counted.
  always_comb begin
    state_d = state_q;
    en      = 1'b0;
    fin     = 1'b0;
    tmo_hit = 1'b0;
    case (state_q)
      IDLE: if (bus.start) state_d = INIT;
      INIT: if (!bus.start) state_d = RUN;
      RUN: begin
        if (bus.start) begin
          state_d = INIT;
        end else if (bus.halt_inst) begin
          state_d = HALT;
          fin     = 1'b1;
        end else begin
          en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = HALT;
            fin     = 1'b1;
            tmo_hit = 1'b1;
          end
        end
      end
      HALT: if (bus.start) state_d = INIT;
      default: state_d = IDLE;
    endcase
    // Clearing on the edge that enters INIT makes the results read zero
    // from the first INIT cycle, including on an abort or a rerun.
    clr = (state_d == INIT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      halt_pc_q <= '0;
      tmo_q     <= 1'b0;
    end else if (clr) begin
      cnt_q     <= '0;
      halt_pc_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      // The cycle bound stops the run at cnt == TIMEOUT, so no wrap.
      if (en) cnt_q <= cnt_q + 1'b1;
      if (fin) begin
        halt_pc_q <= bus.pc;
        tmo_q     <= tmo_hit;
      end
    end
  end

  // state_q resets asynchronously to IDLE, so core_en drops with reset
  // without waiting for a clock.
  assign bus.core_en     = en;
  assign bus.core_init   = (state_q == INIT);
  assign bus.done        = (state_q == HALT);
  assign bus.timeout     = tmo_q;
  assign bus.cycle_count = cnt_q;
  assign bus.halt_pc     = halt_pc_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl -- directed checks of run_ctrl with TIMEOUT=8.
module tb_run_ctrl;
  localparam int PW = 11;
  localparam int CW = 16;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  run_ctrl_if #(.PC_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  run_ctrl #(.PC_WIDTH(PW), .CNT_WIDTH(CW), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Drive n RUN cycles; cycle k presents pc=k-1. halt_inst on cycle halt_at,
  // start on cycle abort_at (0 = never). Returns how many cycles had core_en
  // high and whether done was ever seen.
  task automatic run_cycles(input int n, input int halt_at, input int abort_at,
                            output int en_hi, output int done_seen);
    en_hi = 0;
    done_seen = 0;
    for (int k = 1; k <= n; k++) begin
      bus.pc        = PW'(k - 1);
      bus.halt_inst = (k == halt_at);
      bus.start     = (k == abort_at);
      @(negedge clk);
      en_hi += int'(bus.core_en);
      done_seen += int'(bus.done);
      cyc();
    end
    bus.halt_inst = 1'b0;
  endtask

  // start high one cycle then low: ends at the start of RUN cycle 1
  task automatic launch();
    bus.start = 1'b1;
    cyc();
    chk("init_core_init", 32'(bus.core_init), 32'd1);
    chk("init_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    cyc();
  endtask

  int en_hi;
  int dseen;

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.halt_inst = 1'b0;
    bus.pc = '0;
    #3;
    chk("rst_core_init", 32'(bus.core_init), 32'd0);
    chk("rst_core_en", 32'(bus.core_en), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_timeout", 32'(bus.timeout), 32'd0);
    chk("rst_count", 32'(bus.cycle_count), 32'd0);
    chk("rst_halt_pc", 32'(bus.halt_pc), 32'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // normal run: start for 3 cycles, halt on 5th RUN cycle at pc=4
    bus.start = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("norm_init", 32'(bus.core_init), 32'd1);
    bus.start = 1'b0;
    cyc();
    chk("norm_run_init", 32'(bus.core_init), 32'd0);
    run_cycles(5, 5, 0, en_hi, dseen);
    chk("norm_en_cycles", 32'(en_hi), 32'd4);
    chk("norm_done", 32'(bus.done), 32'd1);
    chk("norm_count", 32'(bus.cycle_count), 32'd4);
    chk("norm_halt_pc", 32'(bus.halt_pc), 32'd4);
    chk("norm_timeout", 32'(bus.timeout), 32'd0);
    chk("norm_halt_en", 32'(bus.core_en), 32'd0);

    // rerun from HALT: done drops on INIT entry, halt after 2 cycles
    bus.start = 1'b1;
    cyc();
    chk("rerun_done", 32'(bus.done), 32'd0);
    chk("rerun_count_clr", 32'(bus.cycle_count), 32'd0);
    chk("rerun_pc_clr", 32'(bus.halt_pc), 32'd0);
    bus.start = 1'b0;
    cyc();
    run_cycles(3, 3, 0, en_hi, dseen);
    chk("rerun_count", 32'(bus.cycle_count), 32'd2);
    chk("rerun_halt_pc", 32'(bus.halt_pc), 32'd2);
    chk("rerun_fin", 32'(bus.done), 32'd1);

    // timeout: no halt for 8 cycles
    launch();
    run_cycles(8, 0, 0, en_hi, dseen);
    chk("tmo_en_cycles", 32'(en_hi), 32'd8);
    chk("tmo_done", 32'(bus.done), 32'd1);
    chk("tmo_timeout", 32'(bus.timeout), 32'd1);
    chk("tmo_count", 32'(bus.cycle_count), 32'd8);
    chk("tmo_halt_pc", 32'(bus.halt_pc), 32'd7);
    bus.pc = PW'(9);
    @(negedge clk);
    chk("tmo_after_en", 32'(bus.core_en), 32'd0);
    cyc();
    chk("tmo_hold_count", 32'(bus.cycle_count), 32'd8);
    chk("tmo_hold_pc", 32'(bus.halt_pc), 32'd7);
    chk("tmo_hold_tmo", 32'(bus.timeout), 32'd1);

    // halt and timeout on the same cycle: halt wins
    launch();
    chk("sim_tmo_clr", 32'(bus.timeout), 32'd0);
    run_cycles(8, 8, 0, en_hi, dseen);
    chk("sim_done", 32'(bus.done), 32'd1);
    chk("sim_timeout", 32'(bus.timeout), 32'd0);
    chk("sim_count", 32'(bus.cycle_count), 32'd7);
    chk("sim_halt_pc", 32'(bus.halt_pc), 32'd7);

    // abort on 3rd RUN cycle
    launch();
    run_cycles(3, 0, 3, en_hi, dseen);
    chk("abort_en_cycles", 32'(en_hi), 32'd2);
    chk("abort_done_seen", 32'(dseen), 32'd0);
    chk("abort_init", 32'(bus.core_init), 32'd1);
    chk("abort_count", 32'(bus.cycle_count), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);

    // async reset mid-RUN, between edges
    bus.start = 1'b0;
    cyc();
    run_cycles(2, 0, 0, en_hi, dseen);
    #1;
    chk("ar_pre_en", 32'(bus.core_en), 32'd1);
    chk("ar_pre_count", 32'(bus.cycle_count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("ar_en", 32'(bus.core_en), 32'd0);
    chk("ar_init", 32'(bus.core_init), 32'd0);
    chk("ar_done", 32'(bus.done), 32'd0);
    chk("ar_count", 32'(bus.cycle_count), 32'd0);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("ar_idle_init", 32'(bus.core_init), 32'd0);
    chk("ar_idle_en", 32'(bus.core_en), 32'd0);
    bus.start = 1'b1;
    cyc();
    chk("ar_restart_init", 32'(bus.core_init), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  // hard bound so the bench always ends
  initial begin
    #20000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
